cordic_gain_fifo: RTL and testbench

//  Stage directly downstream of the pipelined CORDIC rotator. The CORDIC has no valid or stall.

---
 rtl/cordic_gain_fifo.sv | 120 ++++++++++++
 tb/tb_cordic_gain_fifo.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/cordic_gain_fifo.sv
// Gain-correction and output buffer behind a non-stallable pipelined CORDIC.
// Optional macro CORDIC_GAIN_ROUND_EN selects round-half-up instead of truncation in stage 2.
module cordic_gain_fifo #(
  parameter int BIT_WIDTH     = 16,
  parameter int CORDIC_STAGES = 16,
  parameter int GAIN          = 19899,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  input  logic signed [BIT_WIDTH-1:0]       cordic_x,
  input  logic signed [BIT_WIDTH-1:0]       cordic_y,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic signed [BIT_WIDTH-1:0]       out_x,
  output logic signed [BIT_WIDTH-1:0]       out_y,
  output logic [$clog2(FIFO_DEPTH):0]       level,
  output logic                              overflow,
  input  logic                              ovf_clr
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int PW   = 2*BIT_WIDTH+1;
  localparam int FRAC = 15;
  localparam logic signed [BIT_WIDTH:0] L_GAIN = (BIT_WIDTH+1)'(GAIN);
`ifdef CORDIC_GAIN_ROUND_EN
  localparam logic signed [PW-1:0] L_HALF = PW'(2**(FRAC-1));
`endif

  // in_valid travels alongside the CORDIC pipeline; the last tap lines up with its output.
  logic [CORDIC_STAGES:0]    r_vld_dly;
  logic                      w_vld_c;

  logic                      r_v1;
  logic signed [PW-1:0]      r_px;
  logic signed [PW-1:0]      r_py;

  logic                      r_v2;
  logic signed [BIT_WIDTH-1:0] r_sx;
  logic signed [BIT_WIDTH-1:0] r_sy;

  logic [2*BIT_WIDTH-1:0]    r_mem [FIFO_DEPTH];
  logic [AW:0]               r_wr_ptr;
  logic [AW:0]               r_rd_ptr;
  logic                      r_overflow;

  logic [AW:0]               w_level;
  logic                      w_empty;
  logic                      w_full;
  logic                      w_pop;
  logic                      w_do_write;
  logic                      w_drop;
  logic [2*BIT_WIDTH-1:0]    w_head;

  assign w_vld_c = r_vld_dly[CORDIC_STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_dly <= '0;
      r_v1      <= 1'b0;
      r_v2      <= 1'b0;
    end else begin
      r_vld_dly <= {r_vld_dly[CORDIC_STAGES-1:0], in_valid};
      r_v1      <= w_vld_c;
      r_v2      <= r_v1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_vld_c) begin
      r_px <= PW'(cordic_x) * PW'(L_GAIN);
      r_py <= PW'(cordic_y) * PW'(L_GAIN);
    end
    if (r_v1) begin
`ifdef CORDIC_GAIN_ROUND_EN
      r_sx <= BIT_WIDTH'((r_px + L_HALF) >>> FRAC);
      r_sy <= BIT_WIDTH'((r_py + L_HALF) >>> FRAC);
`else
      r_sx <= BIT_WIDTH'(r_px >>> FRAC);
      r_sy <= BIT_WIDTH'(r_py >>> FRAC);
`endif
    end
  end

  // Output handshake: a transfer happens at a rising edge where out_valid && out_ready;
  // out_x/out_y are the registered head entry and stay put until that transfer.
  assign w_level    = r_wr_ptr - r_rd_ptr;
  assign w_empty    = (w_level == '0);
  assign w_full     = (w_level == (AW+1)'(FIFO_DEPTH));
  assign w_pop      = !w_empty && out_ready;
  assign w_do_write = r_v2 && (!w_full || w_pop);
  assign w_drop     = r_v2 && w_full && !w_pop;
  assign w_head     = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_do_write) r_mem[r_wr_ptr[AW-1:0]] <= {r_sx, r_sy};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_do_write) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)      r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      // A drop in the same cycle as a clear must leave the flag set.
      if (w_drop)       r_overflow <= 1'b1;
      else if (ovf_clr) r_overflow <= 1'b0;
    end
  end

  assign out_valid = !w_empty;
  assign out_x     = w_empty ? '0 : w_head[2*BIT_WIDTH-1:BIT_WIDTH];
  assign out_y     = w_empty ? '0 : w_head[BIT_WIDTH-1:0];
  assign level     = w_level;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_cordic_gain_fifo.sv
// Directed scoreboard bench for cordic_gain_fifo; a behavioural CORDIC stand-in
// replays each sample's x/y 17 cycles after its in_valid.
module tb_cordic_gain_fifo;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic signed [15:0] cordic_x;
  logic signed [15:0] cordic_y;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_x;
  logic signed [15:0] out_y;
  logic [3:0]         level;
  logic               overflow;
  logic               ovf_clr;

  int checks;
  int failures;
  int cyc;

  logic [31:0]        exp_q[$];
  logic signed [15:0] dx [32];
  logic signed [15:0] dy [32];

  // Inputs and hand-computed gain-corrected results (truncate / round-half-up).
  int tab_in[16] = '{16384, -16384, 32767, -32768, 0, 1000, -1000, 100,
                     -100, 2000, -2000, 4096, -4096, 8192, -8192, 3000};
  int tab_t[16]  = '{9949, -9950, 19898, -19899, 0, 607, -608, 60,
                     -61, 1214, -1215, 2487, -2488, 4974, -4975, 1821};
  int tab_r[16]  = '{9950, -9949, 19898, -19899, 0, 607, -607, 61,
                     -61, 1215, -1215, 2487, -2487, 4975, -4975, 1822};

  cordic_gain_fifo dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .cordic_x  (cordic_x),
    .cordic_y  (cordic_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_y     (out_y),
    .level     (level),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ev(input int i);
`ifdef CORDIC_GAIN_ROUND_EN
    return tab_r[i];
`else
    return tab_t[i];
`endif
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks = checks + 1;
    if (act != req) begin
      failures = failures + 1;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // One input window: set just after a rising edge, sampled at the next one.
  task automatic step(input logic v, input int xi, input int yi);
    @(posedge clk);
    #1;
    cyc = cyc + 1;
    in_valid = v;
    if (v) begin
      dx[(cyc+17)%32] = 16'(tab_in[xi]);
      dy[(cyc+17)%32] = 16'(tab_in[yi]);
    end
    cordic_x = dx[cyc%32];
    cordic_y = dy[cyc%32];
    dx[cyc%32] = 16'($urandom_range(0, 65535));
    dy[cyc%32] = 16'($urandom_range(0, 65535));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0);
  endtask

  task automatic issue(input int xi, input int yi, input bit keep);
    step(1'b1, xi, yi);
    if (keep) exp_q.push_back({16'(ev(xi)), 16'(ev(yi))});
  endtask

  // Monitor: pops the scoreboard on every accepted output beat.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks = checks + 1;
        failures = failures + 1;
        $display("FAIL spurious_out: got x=%0d y=%0d required no output", out_x, out_y);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("pop_x", int'(out_x), int'($signed(e[31:16])));
        chk("pop_y", int'(out_y), int'($signed(e[15:0])));
      end
    end
  end

  initial begin
    checks = 0; failures = 0; cyc = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
    cordic_x = '0; cordic_y = '0;
    for (int i = 0; i < 32; i++) begin dx[i] = '0; dy[i] = '0; end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_out_x", int'(out_x), 0);
    chk("rst_out_y", int'(out_y), 0);
    rst_n = 1'b1;

    // Single sample latency into an empty FIFO.
    issue(0, 1, 1'b1);
    idle(19);
    chk("t1_valid_edge18", int'(out_valid), 0);
    idle(1);
    chk("t1_valid_edge19", int'(out_valid), 1);
    chk("t1_level", int'(level), 1);
    chk("t1_out_x", int'(out_x), ev(0));
    chk("t1_out_y", int'(out_y), ev(1));
    out_ready = 1'b1;
    idle(3);
    chk("t1_level_drained", int'(level), 0);

    // Extremes and zero, back-to-back.
    issue(2, 3, 1'b1);
    issue(3, 4, 1'b1);
    issue(4, 2, 1'b1);
    idle(25);

    // Backpressure: eight fill the FIFO, the ninth is dropped.
    out_ready = 1'b0;
    for (int i = 5; i < 13; i++) issue(i, (i+3)%16, 1'b1);
    issue(13, 14, 1'b0);
    idle(19);
    chk("t3_level_full", int'(level), 8);
    chk("t3_ovf_before_drop", int'(overflow), 0);
    idle(1);
    chk("t3_level_after_drop", int'(level), 8);
    chk("t3_ovf_after_drop", int'(overflow), 1);
    ovf_clr = 1'b1;
    idle(1);
    ovf_clr = 1'b0;
    chk("t5_ovf_cleared", int'(overflow), 0);
    out_ready = 1'b1;
    idle(12);
    chk("t3_level_drained", int'(level), 0);

    // Full FIFO with a simultaneous push and pop.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) issue(i+8 > 15 ? i : i+8, (i+5)%16, 1'b1);
    idle(22);
    chk("t4_level_full", int'(level), 8);
    issue(15, 2, 1'b1);
    idle(19);
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    chk("t4_level_pushpop", int'(level), 8);
    chk("t4_ovf", int'(overflow), 0);
    out_ready = 1'b1;
    idle(12);
    chk("t4_level_drained", int'(level), 0);

    // Clear in the same cycle as a drop: the drop wins.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) issue(15-i, i, 1'b1);
    issue(6, 7, 1'b0);
    idle(19);
    chk("t5_ovf_pre", int'(overflow), 0);
    ovf_clr = 1'b1;
    idle(1);
    ovf_clr = 1'b0;
    chk("t5_drop_beats_clr", int'(overflow), 1);
    out_ready = 1'b1;
    idle(12);
    chk("t5_level_drained", int'(level), 0);
    ovf_clr = 1'b1;
    idle(1);
    ovf_clr = 1'b0;

    // Asynchronous reset with five samples in flight.
    for (int i = 0; i < 5; i++) issue(i+9, i, 1'b1);
    idle(5);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_valid_in_rst", int'(out_valid), 0);
    chk("t6_level_in_rst", int'(level), 0);
    exp_q.delete();
    idle(2);
    rst_n = 1'b1;
    idle(30);
    chk("t6_level_after", int'(level), 0);
    chk("t6_valid_after", int'(out_valid), 0);

    idle(3);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
